// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator.
//   DEF_ADDR_W / DEF_STEP / DEF_RESET_PC : default parameter values for pc_gen
//   pc_src_e                             : encoding of the selected next-PC source
package pc_pkg;

    localparam int DEF_ADDR_W   = 18;
    localparam int DEF_STEP     = 4;
    localparam int DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        SRC_SEQ   = 2'd0,
        SRC_JUMP  = 2'd1,
        SRC_RET   = 2'd2,
        SRC_REDIR = 2'd3
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer of RAS_DEPTH entries with a top
// pointer and an occupancy count. State updates on the falling clock edge.
//   clk, rst_n        : clock (falling-edge active), async active-low reset
//   push, push_data   : write push_data at top+1; oldest entry lost when full
//   pop               : discard entry[top]; ignored (underflow event) when empty
//   top_data          : entry[top], valid when !empty
//   empty, full       : occupancy status
//   ovf_evt, unf_evt  : single-cycle push-while-full / pop-while-empty events
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              empty,
    output logic              full,
    output logic              ovf_evt,
    output logic              unf_evt
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0]  top;
    logic [PTR_W:0]    count;
    logic [PTR_W-1:0]  top_inc;

    // Pointer arithmetic wraps for free because RAS_DEPTH is a power of two.
    assign top_inc  = top + 1'b1;
    assign top_data = entries[top];
    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(RAS_DEPTH));
    assign ovf_evt  = push && full;
    assign unf_evt  = pop && empty;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            top <= top_inc;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            top   <= top - 1'b1;
            count <= count - 1'b1;
        end
    end

    // NOTE: the entry array has no reset; count gates every read, so the
    // contents never matter until written, and leaving them unreset keeps
    // this a plain register file / RAM.
    always_ff @(negedge clk) begin
        if (push) begin
            entries[top_inc] <= push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Next-fetch-address generator. Chooses between redirect, stall, return,
// jump/call and sequential increment; keeps sticky RAS/conflict flags.
// All state updates on the falling clock edge.
//   clk, rst_n                 : clock (falling-edge active), async active-low reset
//   pc_write                   : 1 = advance, 0 = hold (redirect still applies)
//   redirect_valid/redirect_pc : flush/exception redirect, highest priority
//   jump_valid/jump_target     : taken branch or jump; target is also the
//                                fallback for a return with an empty RAS
//   jump_link                  : marks a jump as a call (pushes pc_plus_step)
//   ret_valid                  : return, pops the RAS
//   pc_out, pc_plus_step       : current fetch address and its increment
//   ras_empty, ras_full        : RAS occupancy
//   ras_overflow/underflow     : sticky RAS misuse flags
//   conflict                   : sticky; jump and return requested together
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                STEP      = DEF_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_write,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              jump_link,
    input  logic              ret_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus_step,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic              conflict
);

    pc_src_e           src;
    logic              advance;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ovf_evt;
    logic              unf_evt;
    logic              conflict_evt;
    logic [ADDR_W-1:0] next_pc;

    assign pc_plus_step = pc_out + ADDR_W'(STEP);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        src          = SRC_SEQ;
        advance      = 1'b1;
        push         = 1'b0;
        pop          = 1'b0;
        conflict_evt = 1'b0;
        if (redirect_valid) begin
            src = SRC_REDIR;
        end else if (!pc_write) begin
            advance = 1'b0;
        end else if (ret_valid) begin
            src          = SRC_RET;
            pop          = 1'b1;
            conflict_evt = jump_valid;
        end else if (jump_valid) begin
            src  = SRC_JUMP;
            push = jump_link;
        end
    end

    always_comb begin
        next_pc = pc_plus_step;
        unique case (src)
            SRC_REDIR: next_pc = redirect_pc;
            SRC_JUMP:  next_pc = jump_target;
            SRC_RET:   next_pc = ras_empty ? jump_target : ras_top;
            SRC_SEQ:   next_pc = pc_plus_step;
        endcase
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus_step),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf_evt   (ovf_evt),
        .unf_evt   (unf_evt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out        <= RESET_PC;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            conflict      <= 1'b0;
        end else begin
            if (advance) begin
                pc_out <= next_pc;
            end
            if (ovf_evt) ras_overflow  <= 1'b1;
            if (unf_evt) ras_underflow <= 1'b1;
            if (conflict_evt) conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (ADDR_W=18, STEP=4, RESET_PC=0,
// RAS_DEPTH=4). Inputs change and outputs are sampled 1 time unit after
// each falling edge, well away from the next active edge.
module tb_pc_gen;

    localparam int ADDR_W = 18;

    logic              clk = 1'b1;
    logic              rst_n;
    logic              pc_write;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_target;
    logic              jump_link;
    logic              ret_valid;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus_step;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_overflow;
    logic              ras_underflow;
    logic              conflict;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W    (ADDR_W),
        .STEP      (4),
        .RESET_PC  (18'h0),
        .RAS_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write       (pc_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .jump_link      (jump_link),
        .ret_valid      (ret_valid),
        .pc_out         (pc_out),
        .pc_plus_step   (pc_plus_step),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full),
        .ras_overflow   (ras_overflow),
        .ras_underflow  (ras_underflow),
        .conflict       (conflict)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [ADDR_W-1:0] addr);
        redirect_valid = 1'b1;
        redirect_pc    = addr;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        pc_write       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        jump_valid     = 1'b0;
        jump_target    = '0;
        jump_link      = 1'b0;
        ret_valid      = 1'b0;

        // Reset state
        #12;
        check("reset_pc", 32'(pc_out), 32'h0);
        check("reset_empty", 32'(ras_empty), 32'h1);
        check("reset_full", 32'(ras_full), 32'h0);
        check("reset_flags", {29'h0, ras_overflow, ras_underflow, conflict}, 32'h0);

        // Sequential increment
        rst_n    = 1'b1;
        pc_write = 1'b1;
        tick(); check("seq_1", 32'(pc_out), 32'h4);
        tick(); check("seq_2", 32'(pc_out), 32'h8);
        tick(); check("seq_3", 32'(pc_out), 32'hC);
        check("seq_step", 32'(pc_plus_step), 32'h10);

        // Asynchronous reset mid-run, observed before any edge
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(pc_out), 32'h0);
        #1 rst_n = 1'b1;
        tick(); check("after_reset", 32'(pc_out), 32'h4);

        // Stall vs redirect
        redirect_to(18'h10);
        check("redir_10", 32'(pc_out), 32'h10);
        pc_write = 1'b0;
        tick(); tick();
        check("stall_hold", 32'(pc_out), 32'h10);
        redirect_to(18'h200);
        check("redir_in_stall", 32'(pc_out), 32'h200);
        pc_write = 1'b1;

        // Call and return
        redirect_to(18'h40);
        jump_valid = 1'b1; jump_link = 1'b1; jump_target = 18'h100;
        tick();
        check("call_pc", 32'(pc_out), 32'h100);
        check("call_not_empty", 32'(ras_empty), 32'h0);
        jump_valid = 1'b0; jump_link = 1'b0;
        tick(); tick();
        check("call_seq", 32'(pc_out), 32'h108);
        ret_valid = 1'b1;
        tick();
        check("ret_pc", 32'(pc_out), 32'h44);
        check("ret_empty", 32'(ras_empty), 32'h1);
        ret_valid = 1'b0;

        // Five chained calls from 0x0, 0x10, 0x20, 0x30, 0x40
        redirect_to(18'h0);
        jump_valid = 1'b1; jump_link = 1'b1;
        jump_target = 18'h10;  tick();
        jump_target = 18'h20;  tick();
        jump_target = 18'h30;  tick();
        jump_target = 18'h40;  tick();
        check("four_calls_full", 32'(ras_full), 32'h1);
        check("four_calls_no_ovf", 32'(ras_overflow), 32'h0);
        jump_target = 18'h500; tick();
        check("fifth_call_pc", 32'(pc_out), 32'h500);
        check("overflow", 32'(ras_overflow), 32'h1);
        check("overflow_full", 32'(ras_full), 32'h1);
        jump_valid = 1'b0; jump_link = 1'b0;

        // Four returns pop the surviving entries newest first
        ret_valid = 1'b1;
        tick(); check("pop_1", 32'(pc_out), 32'h44);
        tick(); check("pop_2", 32'(pc_out), 32'h34);
        tick(); check("pop_3", 32'(pc_out), 32'h24);
        tick(); check("pop_4", 32'(pc_out), 32'h14);
        check("pops_empty", 32'(ras_empty), 32'h1);
        check("no_underflow_yet", 32'(ras_underflow), 32'h0);
        jump_target = 18'h300;
        tick();
        check("underflow_pc", 32'(pc_out), 32'h300);
        check("underflow", 32'(ras_underflow), 32'h1);
        check("underflow_empty", 32'(ras_empty), 32'h1);
        ret_valid = 1'b0;

        // Conflict: return beats a simultaneous call
        redirect_to(18'h20);
        jump_valid = 1'b1; jump_link = 1'b1; jump_target = 18'h600;
        tick();
        check("pre_conflict_pc", 32'(pc_out), 32'h600);
        check("pre_conflict_flag", 32'(conflict), 32'h0);
        jump_target = 18'h80; ret_valid = 1'b1;
        tick();
        check("conflict_pc", 32'(pc_out), 32'h24);
        check("conflict_flag", 32'(conflict), 32'h1);
        check("conflict_no_push", 32'(ras_empty), 32'h1);
        jump_valid = 1'b0; jump_link = 1'b0; jump_target = 18'h700;
        tick();
        check("conflict_ret_fallback", 32'(pc_out), 32'h700);
        ret_valid = 1'b0;

        // jump_link alone is ignored
        jump_link = 1'b1;
        tick();
        check("link_only_seq", 32'(pc_out), 32'h704);
        check("link_only_no_push", 32'(ras_empty), 32'h1);
        jump_link = 1'b0;

        // Address wrap-around
        redirect_to(18'h3FFFC);
        check("wrap_step", 32'(pc_plus_step), 32'h0);
        tick();
        check("wrap_pc", 32'(pc_out), 32'h0);
        check("wrap_step_after", 32'(pc_plus_step), 32'h4);

        // Sticky flags clear only on reset
        check("sticky_held", {29'h0, ras_overflow, ras_underflow, conflict}, 32'h7);
        #2 rst_n = 1'b0;
        #1 check("flags_cleared", {29'h0, ras_overflow, ras_underflow, conflict}, 32'h0);
        check("reset_pc_again", 32'(pc_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter for the pipelined core.
- Selects the next fetch address from these sources: sequential increment, branch/jump target, pipeline redirect (flush/exception), and a small internal return-address stack (RAS) used for call/return.
- Feeds the instruction cache address port; its stall and redirect inputs are driven by the hazard unit.

Parameters:
- ADDR_W, 18, width of every address in bits.
- STEP, 4, sequential increment added to pc_out.
- RESET_PC, 0, value loaded into pc_out on reset.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_write  in  1  1 = PC may advance; 0 = stall (hold).
- redirect_valid  in  1  flush/exception redirect request.
- redirect_pc  in  ADDR_W  redirect target.
- jump_valid  in  1  taken branch or jump.
- jump_target  in  ADDR_W  branch/jump target; also the fallback address for a return when the RAS is empty.
- jump_link  in  1  qualifies jump_valid as a call; pushes the return address.
- ret_valid  in  1  return; pops the RAS.
- pc_out  out  ADDR_W  current fetch address.
- pc_plus_step  out  ADDR_W  pc_out + STEP, combinational, modulo 2^ADDR_W.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_overflow  out  1  sticky; a push occurred while full.
- ras_underflow  out  1  sticky; a pop occurred while empty.
- conflict  out  1  sticky; jump_valid and ret_valid were asserted together.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc_out = RESET_PC.
  - RAS count = 0, top pointer = 0.
  - All sticky flags = 0.
  - This takes effect immediately, even mid-operation; the first update occurs on the first falling edge after rst_n rises.
- Next-PC priority, evaluated at each falling edge:
  1. redirect_valid: pc_out <= redirect_pc. This applies even when pc_write=0. The RAS is untouched and jump/ret are ignored.
  2. pc_write=0: pc_out holds and the RAS holds. No flags are set.
  3. ret_valid:
     - RAS non-empty: pc_out <= RAS top; pop.
     - RAS empty: pc_out <= jump_target; count stays 0; ras_underflow <= 1.
  4. jump_valid: pc_out <= jump_target. If jump_link=1, push pc_plus_step.
  5. Otherwise: pc_out <= pc_plus_step.
- Simultaneous ret_valid and jump_valid (with pc_write=1, no redirect):
  - ret wins and no push occurs.
  - conflict <= 1.
- jump_link without jump_valid is ignored.
- Latency: inputs sampled on a falling edge are reflected on pc_out after that same edge (one-edge latency). No combinational path exists from the inputs to pc_out.
- Arithmetic: all additions truncate to ADDR_W. Example: pc_out = 2^ADDR_W - STEP gives pc_plus_step = 0 (wrap-around, no flag).
- RAS is a circular buffer of RAS_DEPTH entries with a top pointer and a count.
  - Push: write at top+1, advance top, count++. If already full, the oldest entry is overwritten, count stays RAS_DEPTH, and ras_overflow <= 1.
  - Pop: read entry[top], decrement top mod RAS_DEPTH, count--.
- Sticky flags clear only on reset.

Decomposition:
- Shared package pc_pkg holds:
  - the default ADDR_W, STEP and RESET_PC constants;
  - a 2-bit next-PC source encoding {SRC_SEQ, SRC_JUMP, SRC_RET, SRC_REDIR}, used internally and by the assertion bench.
- One sub-module, pc_ras:
  - parametrised by ADDR_W and RAS_DEPTH;
  - inputs: push, pop, push_data;
  - outputs: top_data, empty, full, ovf_evt, unf_evt;
  - shares clk and rst_n.
- pc_gen holds the PC register, the priority mux and the sticky flags.

Test Plan:
- Reset and sequential: hold rst_n=0, release, pc_write=1, 3 edges -> pc_out 0x0, then 0x4, 0x8, 0xC. Assert rst_n mid-run -> pc_out reads 0x0 immediately, before any edge.
- Stall vs redirect: pc_out=0x10, pc_write=0 for 2 edges -> stays 0x10. Then pc_write=0 with redirect_valid=1, redirect_pc=0x200 -> pc_out=0x200 after one edge.
- Call/return: at pc_out=0x40, jump_valid=1, jump_link=1, jump_target=0x100 -> pc_out=0x100, RAS top=0x44. Advance 2 edges, then ret_valid=1 -> pc_out=0x44, ras_empty=1.
- RAS overflow and underflow:
  - Issue 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_overflow=1.
  - 4 returns -> pc_out sequence 0x44, 0x34, 0x24, 0x14.
  - A 5th return with jump_target=0x300 -> pc_out=0x300, ras_underflow=1.
- Conflict: jump_valid=1 (target 0x80) and ret_valid=1 with RAS top=0x24 -> pc_out=0x24, no push, conflict=1.
- Wrap: pc_out=0x3FFFC (ADDR_W=18), pc_write=1 -> pc_out=0x00000 and pc_plus_step=0x00004.
